// File: rtl/fpu_decode_issue.sv
// RV32F decode/issue stage: registered decode into a DEPTH-entry FIFO
// that feeds the FPU over valid/ready, plus sticky fflags accumulation
// and a free-running issue handshake counter.
module fpu_decode_issue #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid_i,
  input  logic [31:0] instr_i,
  output logic        instr_ready_o,
  input  logic [2:0]  frm_i,
  input  logic        flush_i,
  output logic        op_valid_o,
  input  logic        op_ready_i,
  output logic [4:0]  op_o,
  output logic [4:0]  rd_o,
  output logic [4:0]  rs1_o,
  output logic [4:0]  rs2_o,
  output logic [4:0]  rs3_o,
  output logic [2:0]  rm_o,
  output logic        illegal_o,
  input  logic        fflags_valid_i,
  input  logic [4:0]  fflags_i,
  input  logic        fflags_clr_i,
  output logic [4:0]  fflags_o,
  output logic [31:0] issue_cnt_o
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [4:0] OP_ADD      = 5'd0;
  localparam logic [4:0] OP_SUB      = 5'd1;
  localparam logic [4:0] OP_MUL      = 5'd2;
  localparam logic [4:0] OP_DIV      = 5'd3;
  localparam logic [4:0] OP_SQRT     = 5'd4;
  localparam logic [4:0] OP_SGNJ     = 5'd5;
  localparam logic [4:0] OP_SGNJN    = 5'd6;
  localparam logic [4:0] OP_SGNJX    = 5'd7;
  localparam logic [4:0] OP_MIN      = 5'd8;
  localparam logic [4:0] OP_MAX      = 5'd9;
  localparam logic [4:0] OP_CVT_W_S  = 5'd10;
  localparam logic [4:0] OP_CVT_WU_S = 5'd11;
  localparam logic [4:0] OP_CVT_S_W  = 5'd12;
  localparam logic [4:0] OP_CVT_S_WU = 5'd13;
  localparam logic [4:0] OP_FEQ      = 5'd14;
  localparam logic [4:0] OP_FLT      = 5'd15;
  localparam logic [4:0] OP_FLE      = 5'd16;
  localparam logic [4:0] OP_CLASS    = 5'd17;
  localparam logic [4:0] OP_MV_X_W   = 5'd18;
  localparam logic [4:0] OP_MV_W_X   = 5'd19;
  localparam logic [4:0] OP_FMADD    = 5'd20;

  typedef struct packed {
    logic [4:0] op;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rs3;
    logic [2:0] rm;
    logic       ill;
  } dec_t;

  dec_t            mem_q [DEPTH];
  logic [AW-1:0]   wptr_q, rptr_q;
  logic [AW:0]     cnt_q;
  logic [4:0]      fflags_q;
  logic [31:0]     issue_cnt_q;
  dec_t            dec_d, head;
  logic            push, pop;

  // Instruction field decode; illegal encodings still carry register fields.
  always_comb begin
    logic [4:0] f5;
    logic [2:0] f3;
    logic [4:0] rs2f;
    logic       rnd;
    logic       ill;
    logic [4:0] op;
    logic [2:0] rm;
    f5   = instr_i[31:27];
    f3   = instr_i[14:12];
    rs2f = instr_i[24:20];
    rnd  = 1'b0;
    ill  = 1'b0;
    op   = OP_ADD;
    rm   = f3;
    dec_d     = '0;
    dec_d.rd  = instr_i[11:7];
    dec_d.rs1 = instr_i[19:15];
    dec_d.rs2 = rs2f;
    case (instr_i[6:0])
      7'b1010011: begin
        case (f5)
          5'b00000: begin op = OP_ADD; rnd = 1'b1; end
          5'b00001: begin op = OP_SUB; rnd = 1'b1; end
          5'b00010: begin op = OP_MUL; rnd = 1'b1; end
          5'b00011: begin op = OP_DIV; rnd = 1'b1; end
          5'b01011: begin op = OP_SQRT; rnd = 1'b1; ill = (rs2f != 5'd0); end
          5'b00100: begin
            case (f3)
              3'b000:  op = OP_SGNJ;
              3'b001:  op = OP_SGNJN;
              3'b010:  op = OP_SGNJX;
              default: ill = 1'b1;
            endcase
          end
          5'b00101: begin
            case (f3)
              3'b000:  op = OP_MIN;
              3'b001:  op = OP_MAX;
              default: ill = 1'b1;
            endcase
          end
          5'b10100: begin
            case (f3)
              3'b010:  op = OP_FEQ;
              3'b001:  op = OP_FLT;
              3'b000:  op = OP_FLE;
              default: ill = 1'b1;
            endcase
          end
          5'b11000: begin
            rnd = 1'b1;
            case (rs2f)
              5'd0:    op = OP_CVT_W_S;
              5'd1:    op = OP_CVT_WU_S;
              default: ill = 1'b1;
            endcase
          end
          5'b11010: begin
            rnd = 1'b1;
            case (rs2f)
              5'd0:    op = OP_CVT_S_W;
              5'd1:    op = OP_CVT_S_WU;
              default: ill = 1'b1;
            endcase
          end
          5'b11100: begin
            ill = (rs2f != 5'd0);
            case (f3)
              3'b000:  op = OP_MV_X_W;
              3'b001:  op = OP_CLASS;
              default: ill = 1'b1;
            endcase
          end
          5'b11110: begin
            op  = OP_MV_W_X;
            ill = (rs2f != 5'd0) || (f3 != 3'b000);
          end
          default: ill = 1'b1;
        endcase
        if (instr_i[26:25] != 2'b00) ill = 1'b1;
      end
      // FMADD/FMSUB/FNMSUB/FNMADD differ only in instr[3:2]
      7'b1000011, 7'b1000111, 7'b1001011, 7'b1001111: begin
        op        = OP_FMADD + {3'b000, instr_i[3:2]};
        rnd       = 1'b1;
        dec_d.rs3 = instr_i[31:27];
        if (instr_i[26:25] != 2'b00) ill = 1'b1;
      end
      default: ill = 1'b1;
    endcase
    // Dynamic rounding resolves to frm; reserved modes are illegal either way.
    if (rnd) begin
      if (f3 == 3'b111) begin
        rm = frm_i;
        if (frm_i >= 3'b101) ill = 1'b1;
      end else if (f3 == 3'b101 || f3 == 3'b110) begin
        ill = 1'b1;
      end
    end
    if (ill) begin
      op = 5'd0;
      rm = 3'b000;
    end
    dec_d.op  = op;
    dec_d.rm  = rm;
    dec_d.ill = ill;
  end

  // Ready depends only on registered occupancy; flush kills both sides.
  assign instr_ready_o = (cnt_q != DEPTH[AW:0]);
  assign op_valid_o    = (cnt_q != '0);
  assign push          = instr_valid_i & instr_ready_o & ~flush_i;
  assign pop           = op_valid_o & op_ready_i & ~flush_i;

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else if (flush_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // FIFO storage; contents are don't-care while empty since the head is masked.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= dec_d;
  end

  assign head      = op_valid_o ? mem_q[rptr_q] : '0;
  assign op_o      = head.op;
  assign rd_o      = head.rd;
  assign rs1_o     = head.rs1;
  assign rs2_o     = head.rs2;
  assign rs3_o     = head.rs3;
  assign rm_o      = head.rm;
  assign illegal_o = head.ill;

  // Sticky fflags: a same-cycle clear and retire leaves only the new flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  fflags_q <= '0;
    else if (fflags_clr_i && fflags_valid_i)  fflags_q <= fflags_i;
    else if (fflags_clr_i)                    fflags_q <= '0;
    else if (fflags_valid_i)                  fflags_q <= fflags_q | fflags_i;
  end
  assign fflags_o = fflags_q;

  // Count completed issue handshakes; wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      issue_cnt_q <= '0;
    else if (pop) issue_cnt_q <= issue_cnt_q + 32'd1;
  end
  assign issue_cnt_o = issue_cnt_q;

endmodule
